// File: rtl/stack_ctrl.sv
// LIFO stack controller in front of a single-port synchronous RAM.
// Turns single-cycle push/pop requests into RAM write/read transactions.
// It also tracks the stack pointer and reports full, empty and sticky error status.
module stack_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_err,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_data
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StWait} state_e;

  // Count value meaning every RAM entry is occupied.
  localparam logic [ADDR_WIDTH:0] CountFull = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic                  ram_we_q, ram_we_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH:0]   count_m1;
  logic                  full, empty;

  assign full     = (count_q == CountFull);
  assign empty    = (count_q == '0);
  assign count_m1 = count_q - 1'b1;

  // Next-state and registered-output decode; requests only sampled in StIdle.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_we_d   = 1'b0;
    data_d     = data_q;
    valid_d    = 1'b0;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (i_push && !i_pop) begin
          if (!full) begin
            ram_addr_d = count_q[ADDR_WIDTH-1:0];
            ram_data_d = i_data;
            ram_we_d   = 1'b1;
            count_d    = count_q + 1'b1;
            state_d    = StWrite;
          end else begin
            err_d = 1'b1;
          end
        end else if (i_pop && !i_push) begin
          if (!empty) begin
            ram_addr_d = count_m1[ADDR_WIDTH-1:0];
            count_d    = count_m1;
            state_d    = StRead;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      // RAM commits the word at the edge leaving this state.
      StWrite: state_d = StIdle;
      // RAM registers the read word at the edge leaving this state.
      StRead:  state_d = StWait;
      StWait: begin
        data_d  = i_ram_data;
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_we_q   <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_we_q   <= ram_we_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_busy     = (state_q != StIdle);
  assign o_full     = full;
  assign o_empty    = empty;
  assign o_err      = err_q;
  assign o_count    = count_q;
  assign o_ram_addr = ram_addr_q;
  assign o_ram_data = ram_data_q;
  assign o_ram_we   = ram_we_q;

endmodule
